// File: rtl/mul_result_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mul_result_fifo
// Brief    : First-word-fall-through result buffer behind the keyed multiply
//            stage. Captures every in_valid pulse. A push into a full buffer
//            is dropped and flagged with a sticky overflow bit. The buffer
//            drains over a valid/ready handshake. flush discards everything.
// Options  : RESULT_FIFO_ZEROIZE_EN - clear storage slots on pop and on
//            flush, so consumed or discarded products do not linger in mem.
// Revision : 1.0 - initial release
// ============================================================================
module mul_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL_CNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wp;
    logic [c_AW-1:0]  r_rp;
    logic [c_AW:0]    r_count;
    logic             r_overflow;

    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // Handshake decode. A pop frees the head slot in the same edge, so a
    // full buffer still accepts a push when the consumer takes a word.
    always_comb begin
        w_pop  = !empty && out_ready;
        w_push = in_valid && (!full || w_pop);
        w_drop = in_valid && full && !w_pop;
    end

    // Status and head word are derived purely from registered state.
    always_comb begin
        count     = r_count;
        full      = (r_count == c_FULL_CNT);
        empty     = (r_count == '0);
        out_valid = !empty;
        overflow  = r_overflow;
        out_data  = empty ? '0 : r_mem[r_rp];
    end

    // Storage, pointer and occupancy bookkeeping; rst beats flush beats traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
`ifdef RESULT_FIFO_ZEROIZE_EN
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
`endif
        end else begin
`ifdef RESULT_FIFO_ZEROIZE_EN
            // Placed before the push write so that, when both hit the same
            // slot (full with push and pop together), the new data wins.
            if (w_pop) begin
                r_mem[r_rp] <= '0;
            end
`endif
            if (w_push) begin
                r_mem[r_wp] <= in_data;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_result_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mul_result_fifo
// Brief    : Self-checking bench for mul_result_fifo. A scoreboard queue holds
//            the words expected at the output; status outputs are compared
//            against the queue every cycle. Directed scenarios cover ordering,
//            overflow, full push+pop, pointer wrap, flush and reset. Storage
//            contents are checked hierarchically for the zeroize option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_result_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef RESULT_FIFO_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;

    mul_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb [$];
    logic        m_ovf;
    logic [31:0] last_out;
    int          n_popped;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs with the model at negedge, advance the model
    // with the current inputs, then step past the rising edge.
    task automatic cycle();
        int   n;
        logic pop;
        @(negedge clk);
        n = sb.size();
        check("count",     32'(count),     32'(n));
        check("out_valid", 32'(out_valid), 32'(n != 0));
        check("empty",     32'(empty),     32'(n == 0));
        check("full",      32'(full),      32'(n == DEPTH));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("out_data",  out_data,       (n != 0) ? sb[0] : 32'h0);
        pop = !rst && (n != 0) && out_ready;
        if (pop) begin
            last_out = sb.pop_front();
            n_popped++;
        end
        if (rst || flush) begin
            sb.delete();
            m_ovf = 1'b0;
        end else if (in_valid) begin
            if (n < DEPTH || pop) sb.push_back(in_data);
            else                  m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        cycle();
    endtask

    initial begin
        logic [31:0] exp_mem [DEPTH];

        // Reset, with a push presented that must be ignored.
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        flush = 1'b0; out_ready = 1'b0; m_ovf = 1'b0;
        last_out = '0; n_popped = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_count",     32'(count),     32'd0);
        for (int i = 0; i < DEPTH; i++) check("rst_mem", dut.r_mem[i], 32'd0);

        // Basic FIFO ordering.
        drive(1'b1, 32'h1, 1'b0, 1'b0);
        drive(1'b1, 32'h2, 1'b0, 1'b0);
        drive(1'b1, 32'h3, 1'b0, 1'b0);
        check("t1_count", 32'(count), 32'd3);
        check("t1_head",  out_data,   32'h1);
        repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t1_last",  last_out,    32'h3);
        check("t1_empty", 32'(empty),  32'd1);
        check("t1_data",  out_data,    32'd0);

        // Overfill by one: last push dropped, overflow sticky.
        for (int i = 0; i < 5; i++) drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        check("t2_full",  32'(full),     32'd1);
        check("t2_count", 32'(count),    32'd4);
        check("t2_ovf",   32'(overflow), 32'd1);
        n_popped = 0;
        repeat (5) drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t2_drained", 32'(n_popped), 32'd4);
        check("t2_last",    last_out,      32'hA3);

        // Clear overflow, then push and pop together while full.
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check("t3_ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'hB0, 1'b1, 1'b0);
        check("t3_count", 32'(count),    32'd4);
        check("t3_ovf",   32'(overflow), 32'd0);
        check("t3_slot0", dut.r_mem[0],  32'hB0);
        repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t3_last", last_out, 32'hB0);

        // Interleaved traffic across several pointer wraps.
        n_popped = 0;
        for (int i = 0; i < 16; i++)
            drive(i < 11, 32'h100 + 32'(i), (i % 3) != 0, 1'b0);
        repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t4_popped", 32'(n_popped), 32'd11);
        check("t4_last",   last_out,      32'h10A);
        check("t4_empty",  32'(empty),    32'd1);

        // Flush beats a concurrent push and clears overflow.
        for (int i = 0; i < 5; i++) drive(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_count", 32'(count),    32'd3);
        check("t5_ovf",   32'(overflow), 32'd1);
        drive(1'b1, 32'hCC, 1'b0, 1'b1);
        check("t5_count0", 32'(count),    32'd0);
        check("t5_empty",  32'(empty),    32'd1);
        check("t5_ovf0",   32'(overflow), 32'd0);
        repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_valid", 32'(out_valid), 32'd0);

        // Storage contents after pop and after flush.
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t6_pop_slot", dut.r_mem[0], ZEROIZE ? 32'h0 : 32'h1234_5678);
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        drive(1'b1, 32'h66, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        exp_mem[0] = 32'h1234_5678;
        exp_mem[1] = 32'h55;
        exp_mem[2] = 32'h66;
        exp_mem[3] = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ZEROIZE)    check("t6_flush_mem", dut.r_mem[i], 32'h0);
            else if (i < 3) check("t6_stale_mem", dut.r_mem[i], exp_mem[i]);
        end

        // Reset mid-stream loses held data, then operation resumes.
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        drive(1'b1, 32'h88, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        check("t7_count", 32'(count), 32'd0);
        check("t7_data",  out_data,   32'd0);
        for (int i = 0; i < DEPTH; i++) check("t7_mem", dut.r_mem[i], 32'd0);
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        check("t7_head", out_data, 32'h99);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
